// File: rtl/stopwatch_core.sv
// Centisecond stopwatch: prescaled tick drives a centisec/sec counter pair under a
// ZERO/RUN/PAUSE FSM. The output count is sec*100+centisec, registered one clock behind.
module stopwatch_core #(
  parameter int CLK_HZ  = 100_000_000,
  parameter int TICK_HZ = 100,
  parameter int MAX_SEC = 99
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        run_stop,
  input  logic        clear,
  output logic [13:0] stopwatch_count,
  output logic        running,
  output logic        wrap,
  output logic        tick_10ms
);

  localparam int            DIV  = CLK_HZ / TICK_HZ;
  localparam int            PW   = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [PW-1:0] TERM = PW'(DIV - 1);
  localparam logic [6:0]    SMAX = 7'(MAX_SEC);

  typedef enum logic [1:0] {ZERO, RUN, PAUSE} state_e;

  state_e        state_q, state_d;
  logic [PW-1:0] presc_q, presc_d;
  logic [6:0]    centi_q, centi_d;
  logic [6:0]    sec_q, sec_d;
  logic [13:0]   count_q;
  logic          running_q, wrap_q, tick_q;
  logic          wrap_d, tick_d;
  logic          tick, carry;

  always_comb begin
    state_d = state_q;
    presc_d = presc_q;
    centi_d = centi_q;
    sec_d   = sec_q;
    wrap_d  = 1'b0;
    tick_d  = 1'b0;
    // Tick is gated by the current state, so a tick landing on the cycle
    // run_stop drops is still counted.
    tick    = (state_q == RUN) && (presc_q == TERM);
    carry   = tick && (centi_q == 7'd99);

    case (state_q)
      ZERO:    if (run_stop)  state_d = RUN;
      RUN:     if (!run_stop) state_d = PAUSE;
      PAUSE:   if (run_stop)  state_d = RUN;
      default: state_d = ZERO;
    endcase

    if (state_q == RUN) presc_d = tick ? '0 : presc_q + 1'b1;

    if (tick) begin
      tick_d  = 1'b1;
      centi_d = (centi_q == 7'd99) ? 7'd0 : centi_q + 7'd1;
      if (carry) begin
        sec_d  = (sec_q == SMAX) ? 7'd0 : sec_q + 7'd1;
        wrap_d = (sec_q == SMAX);
      end
    end

    // Clear beats a coincident tick; the run level alone picks RUN or ZERO.
    if (clear) begin
      presc_d = '0;
      centi_d = 7'd0;
      sec_d   = 7'd0;
      tick_d  = 1'b0;
      wrap_d  = 1'b0;
      state_d = run_stop ? RUN : ZERO;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= ZERO;
      presc_q   <= '0;
      centi_q   <= 7'd0;
      sec_q     <= 7'd0;
      count_q   <= 14'd0;
      running_q <= 1'b0;
      wrap_q    <= 1'b0;
      tick_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      presc_q   <= presc_d;
      centi_q   <= centi_d;
      sec_q     <= sec_d;
      count_q   <= {7'd0, sec_q} * 14'd100 + {7'd0, centi_q};
      running_q <= (state_d == RUN);
      wrap_q    <= wrap_d;
      tick_q    <= tick_d;
    end
  end

  assign stopwatch_count = count_q;
  assign running         = running_q;
  assign wrap            = wrap_q;
  assign tick_10ms       = tick_q;

endmodule

// File: tb/tb_stopwatch_core.sv
// Bench for stopwatch_core: a slow instance (10 clocks/tick) with a count scoreboard,
// plus two fast instances (2 clocks/tick) for the wrap and async-reset scenarios.
module tb_stopwatch_core;

  logic        clk, reset;
  logic        run_m, clr_m, run_w, clr_w, run_s, clr_s;
  logic [13:0] cnt_m, cnt_w, cnt_s;
  logic        running_m, wrap_m, tick_m;
  logic        running_w, wrap_w, tick_w;
  logic        running_s, wrap_s, tick_s;

  int          n_chk = 0;
  int          n_fail = 0;
  logic [13:0] exp_q[$];
  logic [13:0] mon_prev = 14'd0;

  stopwatch_core #(.CLK_HZ(1000), .TICK_HZ(100), .MAX_SEC(99)) u_dut (
    .clk(clk), .reset(reset), .run_stop(run_m), .clear(clr_m),
    .stopwatch_count(cnt_m), .running(running_m), .wrap(wrap_m), .tick_10ms(tick_m));

  stopwatch_core #(.CLK_HZ(200), .TICK_HZ(100), .MAX_SEC(99)) u_w (
    .clk(clk), .reset(reset), .run_stop(run_w), .clear(clr_w),
    .stopwatch_count(cnt_w), .running(running_w), .wrap(wrap_w), .tick_10ms(tick_w));

  stopwatch_core #(.CLK_HZ(200), .TICK_HZ(100), .MAX_SEC(5)) u_s (
    .clk(clk), .reset(reset), .run_stop(run_s), .clear(clr_s),
    .stopwatch_count(cnt_s), .running(running_s), .wrap(wrap_s), .tick_10ms(tick_s));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Every change of the slow instance's count must match the next expected value.
  always @(negedge clk) begin
    if (cnt_m !== mon_prev) begin
      n_chk++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL scoreboard_unexpected: got %0d expected no change", cnt_m);
      end else begin
        logic [13:0] e;
        e = exp_q.pop_front();
        if (cnt_m !== e) begin
          n_fail++;
          $display("FAIL scoreboard_count: got %0d expected %0d", cnt_m, e);
        end
      end
      mon_prev = cnt_m;
    end
  end

  task automatic test_reset();
    reset = 1'b0;
    run_m = 0; clr_m = 0; run_w = 0; clr_w = 0; run_s = 0; clr_s = 0;
    repeat (3) @(negedge clk);
    n_chk++;
    if ({cnt_m, running_m, wrap_m, tick_m} !== 17'd0) begin
      n_fail++; $display("FAIL reset_outputs: got %h expected 0", {cnt_m, running_m, wrap_m, tick_m});
    end
    n_chk++;
    if ({cnt_w, cnt_s, running_w, running_s} !== 30'd0) begin
      n_fail++; $display("FAIL reset_fast: got %h expected 0", {cnt_w, cnt_s, running_w, running_s});
    end
    reset = 1'b1;
    repeat (2) @(negedge clk);
    n_chk++;
    if (running_m !== 1'b0) begin
      n_fail++; $display("FAIL reset_idle_running: got %b expected 0", running_m);
    end
  endtask

  task automatic test_run();
    int n_tick = 0;
    for (int k = 1; k <= 100; k++) exp_q.push_back(14'(k));
    run_m = 1'b1;
    repeat (1002) begin
      @(negedge clk);
      if (tick_m) n_tick++;
    end
    n_chk++;
    if (n_tick != 100) begin n_fail++; $display("FAIL run_ticks: got %0d expected 100", n_tick); end
    n_chk++;
    if (cnt_m !== 14'd100) begin n_fail++; $display("FAIL run_count: got %0d expected 100", cnt_m); end
    n_chk++;
    if (running_m !== 1'b1) begin n_fail++; $display("FAIL run_running: got %b expected 1", running_m); end
  endtask

  task automatic test_pause();
    int at = 0;
    clr_m = 1'b1; run_m = 1'b0; exp_q.push_back(14'd0);
    @(negedge clk); clr_m = 1'b0;
    @(negedge clk);
    n_chk++;
    if (running_m !== 1'b0) begin n_fail++; $display("FAIL pause_clear_stop: got %b expected 0", running_m); end
    exp_q.push_back(14'd1); exp_q.push_back(14'd2); exp_q.push_back(14'd3);
    run_m = 1'b1;
    repeat (25) @(negedge clk);
    run_m = 1'b0;
    repeat (50) @(negedge clk);
    n_chk++;
    if (cnt_m !== 14'd2) begin n_fail++; $display("FAIL pause_hold: got %0d expected 2", cnt_m); end
    n_chk++;
    if (running_m !== 1'b0) begin n_fail++; $display("FAIL pause_running: got %b expected 0", running_m); end
    run_m = 1'b1;
    for (int i = 1; i <= 10; i++) begin
      @(negedge clk);
      if (tick_m && at == 0) at = i;
    end
    // Half the tick period was spent before the pause: 1 sync edge + 5 remaining.
    n_chk++;
    if (at != 6) begin n_fail++; $display("FAIL pause_resume_tick: got %0d expected 6", at); end
    n_chk++;
    if (cnt_m !== 14'd3) begin n_fail++; $display("FAIL pause_resume_count: got %0d expected 3", cnt_m); end
  endtask

  task automatic test_clear_paused();
    int at = 0;
    clr_m = 1'b1; run_m = 1'b0; exp_q.push_back(14'd0);
    @(negedge clk); clr_m = 1'b0;
    @(negedge clk);
    for (int k = 1; k <= 1234; k++) exp_q.push_back(14'(k));
    run_m = 1'b1;
    for (int i = 0; i < 13000 && cnt_m != 14'd1234; i++) @(negedge clk);
    run_m = 1'b0;
    repeat (20) @(negedge clk);
    n_chk++;
    if (cnt_m !== 14'd1234) begin n_fail++; $display("FAIL clrp_reach: got %0d expected 1234", cnt_m); end
    n_chk++;
    if (running_m !== 1'b0) begin n_fail++; $display("FAIL clrp_paused: got %b expected 0", running_m); end
    clr_m = 1'b1; exp_q.push_back(14'd0);
    @(negedge clk); clr_m = 1'b0;
    n_chk++;
    if (cnt_m !== 14'd1234) begin n_fail++; $display("FAIL clrp_lag: got %0d expected 1234", cnt_m); end
    @(negedge clk);
    n_chk++;
    if (cnt_m !== 14'd0 || running_m !== 1'b0) begin
      n_fail++; $display("FAIL clrp_zero: got %0d/%b expected 0/0", cnt_m, running_m);
    end
    exp_q.push_back(14'd1);
    run_m = 1'b1;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      if (cnt_m == 14'd1 && at == 0) at = i;
    end
    n_chk++;
    if (at != 12) begin n_fail++; $display("FAIL clrp_restart: got %0d expected 12", at); end
  endtask

  task automatic test_clear_tick();
    int at = 0;
    clr_m = 1'b1; exp_q.push_back(14'd0);
    for (int k = 1; k <= 57; k++) exp_q.push_back(14'(k));
    exp_q.push_back(14'd0); exp_q.push_back(14'd1);
    @(negedge clk); clr_m = 1'b0;
    // Counters zeroed at that edge; tick k lands 10*k edges later.
    repeat (579) @(negedge clk);
    n_chk++;
    if (cnt_m !== 14'd57) begin n_fail++; $display("FAIL clrt_pre: got %0d expected 57", cnt_m); end
    clr_m = 1'b1;
    @(negedge clk); clr_m = 1'b0;
    n_chk++;
    if (tick_m !== 1'b0) begin n_fail++; $display("FAIL clrt_no_tick: got %b expected 0", tick_m); end
    @(negedge clk);
    n_chk++;
    if (cnt_m !== 14'd0 || running_m !== 1'b1) begin
      n_fail++; $display("FAIL clrt_zero_run: got %0d/%b expected 0/1", cnt_m, running_m);
    end
    for (int i = 1; i <= 15; i++) begin
      @(negedge clk);
      if (cnt_m == 14'd1 && at == 0) at = i;
    end
    n_chk++;
    if (at != 10) begin n_fail++; $display("FAIL clrt_continue: got %0d expected 10", at); end
    clr_m = 1'b1; run_m = 1'b0; exp_q.push_back(14'd0);
    @(negedge clk); clr_m = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_wrap();
    int seen = 0;
    run_s = 1'b1;
    for (int i = 0; i < 1400 && seen == 0; i++) begin
      @(negedge clk);
      if (wrap_s) begin
        seen = 1;
        n_chk++;
        if (cnt_s !== 14'd599 || running_s !== 1'b1) begin
          n_fail++; $display("FAIL wrap5_at: got %0d/%b expected 599/1", cnt_s, running_s);
        end
        @(negedge clk);
        n_chk++;
        if (wrap_s !== 1'b0 || cnt_s !== 14'd0 || running_s !== 1'b1) begin
          n_fail++; $display("FAIL wrap5_after: got %b/%0d/%b expected 0/0/1", wrap_s, cnt_s, running_s);
        end
      end
    end
    n_chk++;
    if (seen == 0) begin n_fail++; $display("FAIL wrap5_timeout: got no wrap expected one"); end
    run_s = 1'b0;
    seen = 0;
    run_w = 1'b1;
    for (int i = 0; i < 21000 && seen == 0; i++) begin
      @(negedge clk);
      if (wrap_w) begin
        seen = 1;
        n_chk++;
        if (cnt_w !== 14'd9999 || running_w !== 1'b1) begin
          n_fail++; $display("FAIL wrap99_at: got %0d/%b expected 9999/1", cnt_w, running_w);
        end
        @(negedge clk);
        n_chk++;
        if (wrap_w !== 1'b0 || cnt_w !== 14'd0 || running_w !== 1'b1) begin
          n_fail++; $display("FAIL wrap99_after: got %b/%0d/%b expected 0/0/1", wrap_w, cnt_w, running_w);
        end
      end
    end
    n_chk++;
    if (seen == 0) begin n_fail++; $display("FAIL wrap99_timeout: got no wrap expected one"); end
  endtask

  task automatic test_async_reset();
    for (int i = 0; i < 9000 && cnt_w != 14'd4321; i++) @(negedge clk);
    n_chk++;
    if (cnt_w !== 14'd4321) begin n_fail++; $display("FAIL areset_reach: got %0d expected 4321", cnt_w); end
    #2 reset = 1'b0;
    #1;
    n_chk++;
    if ({cnt_w, running_w, wrap_w, tick_w} !== 17'd0) begin
      n_fail++; $display("FAIL areset_immediate: got %h expected 0", {cnt_w, running_w, wrap_w, tick_w});
    end
    run_w = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    repeat (5) @(negedge clk);
    n_chk++;
    if (running_w !== 1'b0 || cnt_w !== 14'd0) begin
      n_fail++; $display("FAIL areset_idle: got %b/%0d expected 0/0", running_w, cnt_w);
    end
    run_w = 1'b1;
    @(negedge clk);
    n_chk++;
    if (running_w !== 1'b1) begin n_fail++; $display("FAIL areset_start: got %b expected 1", running_w); end
  endtask

  initial begin
    test_reset();
    test_run();
    test_pause();
    test_clear_paused();
    test_clear_tick();
    test_wrap();
    test_async_reset();
    repeat (2) @(negedge clk);
    n_chk++;
    if (exp_q.size() != 0) begin
      n_fail++; $display("FAIL scoreboard_drain: got %0d pending expected 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
